// File: rtl/cafe_pkg.sv
// Shared types, phase/unit tables and sequencing helpers for the coffee preparation back end.
package cafe_pkg;

  typedef enum logic [2:0] {
    REPOSO    = 3'd0,
    AGUA      = 3'd1,
    CAFE      = 3'd2,
    LECHE     = 3'd3,
    CHOCOLATE = 3'd4,
    SERVIR    = 3'd5,
    LISTO     = 3'd6
  } estado_t;

  typedef enum logic [1:0] {
    NEGRO     = 2'd0,
    CON_LECHE = 2'd1,
    CAPUCCINO = 2'd2,
    MOCA      = 2'd3
  } tipo_cafe_t;

  typedef struct packed {
    logic valvula_agua;
    logic molino_cafe;
    logic valvula_leche;
    logic dosif_chocolate;
    logic servir;
    logic ocupado;
    logic listo;
    logic abortado;
  } salidas_t;

  localparam int unsigned NUM_TIPOS       = 4;
  localparam int unsigned NUM_FASES       = 5;
  localparam int unsigned UNIDADES_SERVIR = 2;

  // Units per timed phase (AGUA..SERVIR), one row per coffee type
  localparam int unsigned UNIDADES [NUM_TIPOS][NUM_FASES] = '{
    '{3, 4, 0, 0, UNIDADES_SERVIR},
    '{3, 3, 2, 0, UNIDADES_SERVIR},
    '{3, 2, 3, 0, UNIDADES_SERVIR},
    '{3, 3, 2, 2, UNIDADES_SERVIR}
  };

  function automatic int unsigned unidades(estado_t e, tipo_cafe_t t);
    logic [2:0] idx;
    idx = 3'(e) - 3'd1;
    if (e >= AGUA && e <= SERVIR) return UNIDADES[t][idx];
    return 0;
  endfunction

  // First phase after e with a non-zero duration; zero-unit phases cost no cycle
  function automatic estado_t fase_siguiente(estado_t e, tipo_cafe_t t);
    estado_t sig;
    sig = LISTO;
    for (int f = int'(NUM_FASES); f >= 1; f--) begin
      if (f > int'(e) && unidades(estado_t'(3'(f)), t) != 0) sig = estado_t'(3'(f));
    end
    return sig;
  endfunction

endpackage

// File: rtl/preparador_cafe_if.sv
// Request/status bundle between the payment verifier, front panel and the preparer.
interface preparador_cafe_if;
  logic       iniciarProceso;
  logic [1:0] tipoCafe;
  logic       cancelar;
  logic       valvula_agua;
  logic       molino_cafe;
  logic       valvula_leche;
  logic       dosif_chocolate;
  logic       servir;
  logic       ocupado;
  logic       listo;
  logic       abortado;
  logic [2:0] fase;

  modport master (
    output iniciarProceso, tipoCafe, cancelar,
    input  valvula_agua, molino_cafe, valvula_leche, dosif_chocolate, servir,
    input  ocupado, listo, abortado, fase
  );

  modport slave (
    input  iniciarProceso, tipoCafe, cancelar,
    output valvula_agua, molino_cafe, valvula_leche, dosif_chocolate, servir,
    output ocupado, listo, abortado, fase
  );
endinterface

// File: rtl/temporizador_fase.sv
// Loadable phase down-counter; holds at zero and flags expiry while zero.
module temporizador_fase #(
  parameter int unsigned ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cargar,
  input  logic [ANCHO-1:0] valor,
  output logic             expirado
);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (cargar)                cuenta_d = valor;
    else if (cuenta_q != '0)   cuenta_d = cuenta_q - ANCHO'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cuenta_q <= '0;
    else        cuenta_q <= cuenta_d;
  end

  assign expirado = (cuenta_q == '0);

endmodule

// File: rtl/preparador_cafe.sv
// Coffee preparation sequencer: timed actuator phases per coffee type, with cancel and status pulses.
module preparador_cafe
  import cafe_pkg::*;
#(
  parameter int unsigned CICLOS_POR_UNIDAD = 4
) (
  input logic               clk,
  input logic               rst_n,
  preparador_cafe_if.slave  bus
);

  localparam int unsigned ANCHO_TEMP = $clog2(4 * CICLOS_POR_UNIDAD);

  estado_t    estado_q, estado_d;
  tipo_cafe_t tipo_q, tipo_d;
  logic       armado_q;
  salidas_t   salidas_q, salidas_d;
  logic       inicio_c;
  logic       aborto_c;
  logic       expirado;
  logic       cargar;
  logic [ANCHO_TEMP-1:0] valor;

  function automatic logic [ANCHO_TEMP-1:0] duracion(estado_t e, tipo_cafe_t t);
    int unsigned u;
    u = unidades(e, t);
    if (u == 0) return '0;
    return ANCHO_TEMP'(u * CICLOS_POR_UNIDAD - 1);
  endfunction

  // armado_q is set only after iniciarProceso was seen low, so a level high out of reset cannot start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      tipo_q    <= NEGRO;
      armado_q  <= 1'b0;
      salidas_q <= '0;
    end else begin
      estado_q  <= estado_d;
      tipo_q    <= tipo_d;
      armado_q  <= ~bus.iniciarProceso;
      salidas_q <= salidas_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    tipo_d   = tipo_q;
    aborto_c = 1'b0;
    inicio_c = bus.iniciarProceso & armado_q;
    unique case (estado_q)
      REPOSO: begin
        if (inicio_c && !bus.cancelar) begin
          tipo_d   = tipo_cafe_t'(bus.tipoCafe);
          estado_d = fase_siguiente(REPOSO, tipo_d);
        end
      end
      AGUA, CAFE, LECHE, CHOCOLATE: begin
        if (bus.cancelar) begin
          estado_d = REPOSO;
          aborto_c = 1'b1;
        end else if (expirado) begin
          estado_d = fase_siguiente(estado_q, tipo_q);
        end
      end
      SERVIR:  if (expirado) estado_d = LISTO;
      LISTO:   estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with estado_q
  always_comb begin
    salidas_d = '0;
    unique case (estado_d)
      AGUA:      begin salidas_d.valvula_agua    = 1'b1; salidas_d.ocupado = 1'b1; end
      CAFE:      begin salidas_d.molino_cafe     = 1'b1; salidas_d.ocupado = 1'b1; end
      LECHE:     begin salidas_d.valvula_leche   = 1'b1; salidas_d.ocupado = 1'b1; end
      CHOCOLATE: begin salidas_d.dosif_chocolate = 1'b1; salidas_d.ocupado = 1'b1; end
      SERVIR:    begin salidas_d.servir          = 1'b1; salidas_d.ocupado = 1'b1; end
      LISTO:     salidas_d.listo = 1'b1;
      default:   ;
    endcase
    salidas_d.abortado = aborto_c;
  end

  // Every state change reloads the timer; non-timed states load zero
  assign cargar = (estado_d != estado_q);
  assign valor  = duracion(estado_d, tipo_d);

  temporizador_fase #(
    .ANCHO (ANCHO_TEMP)
  ) u_temporizador (
    .clk      (clk),
    .rst_n    (rst_n),
    .cargar   (cargar),
    .valor    (valor),
    .expirado (expirado)
  );

  assign bus.valvula_agua    = salidas_q.valvula_agua;
  assign bus.molino_cafe     = salidas_q.molino_cafe;
  assign bus.valvula_leche   = salidas_q.valvula_leche;
  assign bus.dosif_chocolate = salidas_q.dosif_chocolate;
  assign bus.servir          = salidas_q.servir;
  assign bus.ocupado         = salidas_q.ocupado;
  assign bus.listo           = salidas_q.listo;
  assign bus.abortado        = salidas_q.abortado;
  assign bus.fase            = 3'(estado_q);

endmodule

// File: tb/tb_preparador_cafe.sv
// Directed bench for preparador_cafe with CICLOS_POR_UNIDAD=4; cycle 0 is the start-edge cycle.
module tb_preparador_cafe;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  preparador_cafe_if bus();

  preparador_cafe #(.CICLOS_POR_UNIDAD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {fase, agua, molino, leche, chocolate, servir, ocupado, listo, abortado}
  function automatic logic [10:0] obs();
    return {bus.fase, bus.valvula_agua, bus.molino_cafe, bus.valvula_leche,
            bus.dosif_chocolate, bus.servir, bus.ocupado, bus.listo, bus.abortado};
  endfunction

  // Expected vector at cycle c given the last cycle of each phase (hand-computed per type)
  function automatic logic [10:0] esperado(int c, int a, int cf, int l, int ch, int s);
    if (c < 1)      return '0;
    if (c <= a)     return {3'd1, 8'b1000_0100};
    if (c <= cf)    return {3'd2, 8'b0100_0100};
    if (c <= l)     return {3'd3, 8'b0010_0100};
    if (c <= ch)    return {3'd4, 8'b0001_0100};
    if (c <= s)     return {3'd5, 8'b0000_1100};
    if (c == s + 1) return {3'd6, 8'b0000_0010};
    return '0;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic arranque(input logic [1:0] t);
    ciclo();
    bus.iniciarProceso = 1'b0;
    ciclo();
    bus.iniciarProceso = 1'b1;
    bus.tipoCafe       = t;
  endtask

  task automatic test_reset();
    logic [10:0] v;
    rst_n = 1'b0;
    bus.iniciarProceso = 1'b0;
    bus.tipoCafe       = 2'd0;
    bus.cancelar       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = obs();
    checks++;
    if (v !== 11'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", v, 11'd0);
    end
    ciclo();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== 11'd0) begin
        failures++;
        $display("FAIL reset_idle k=%0d got=%h exp=%h", c, v, 11'd0);
      end
    end
  endtask

  task automatic test_negro();
    logic [10:0] v, e;
    arranque(2'd0);
    for (int c = 1; c <= 40; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 28, 28, 28, 36);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL negro c=%0d got=%h exp=%h", c, v, e);
      end
    end
  endtask

  task automatic test_moca();
    logic [10:0] v, e;
    arranque(2'd3);
    for (int c = 1; c <= 52; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 24, 32, 40, 48);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL moca c=%0d got=%h exp=%h", c, v, e);
      end
    end
  endtask

  task automatic test_cancelar();
    logic [10:0] v, e;
    arranque(2'd1);
    for (int c = 1; c <= 30; c++) begin
      ciclo();
      bus.cancelar = (c == 15);
      @(negedge clk);
      v = obs();
      if (c <= 15)      e = esperado(c, 12, 24, 32, 32, 40);
      else if (c == 16) e = {3'd0, 8'b0000_0001};
      else              e = '0;
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL cancelar c=%0d got=%h exp=%h", c, v, e);
      end
    end
    bus.cancelar = 1'b0;
  endtask

  task automatic test_cancelar_servir();
    logic [10:0] v, e;
    arranque(2'd0);
    for (int c = 1; c <= 40; c++) begin
      ciclo();
      bus.cancelar = (c >= 30 && c <= 33);
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 28, 28, 28, 36);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL cancelar_servir c=%0d got=%h exp=%h", c, v, e);
      end
    end
    bus.cancelar = 1'b0;
  endtask

  task automatic test_nivel();
    logic [10:0] v, e;
    arranque(2'd2);
    for (int c = 1; c <= 60; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 20, 32, 32, 40);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL nivel_sostenido c=%0d got=%h exp=%h", c, v, e);
      end
    end
    arranque(2'd2);
    for (int c = 1; c <= 44; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 20, 32, 32, 40);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL nivel_rearme c=%0d got=%h exp=%h", c, v, e);
      end
    end
  endtask

  task automatic test_cambio_tipo();
    logic [10:0] v, e;
    arranque(2'd0);
    for (int c = 1; c <= 40; c++) begin
      ciclo();
      if (c == 5) bus.tipoCafe = 2'd2;
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 28, 28, 28, 36);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL cambio_tipo c=%0d got=%h exp=%h", c, v, e);
      end
    end
  endtask

  task automatic test_cancelar_reposo();
    logic [10:0] v;
    ciclo();
    bus.iniciarProceso = 1'b0;
    ciclo();
    bus.iniciarProceso = 1'b1;
    bus.cancelar       = 1'b1;
    ciclo();
    bus.cancelar = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== 11'd0) begin
        failures++;
        $display("FAIL cancelar_reposo k=%0d got=%h exp=%h", c, v, 11'd0);
      end
      ciclo();
    end
  endtask

  task automatic test_reset_medio();
    logic [10:0] v, e;
    arranque(2'd0);
    for (int c = 1; c <= 20; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 28, 28, 28, 36);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL reset_medio_pre c=%0d got=%h exp=%h", c, v, e);
      end
    end
    #1 rst_n = 1'b0;
    #1 v = obs();
    checks++;
    if (v !== 11'd0) begin
      failures++;
      $display("FAIL reset_medio_async got=%h exp=%h", v, 11'd0);
    end
    ciclo();
    ciclo();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      checks++;
      if (v !== 11'd0) begin
        failures++;
        $display("FAIL reset_medio_sin_inicio k=%0d got=%h exp=%h", k, v, 11'd0);
      end
    end
    arranque(2'd0);
    for (int c = 1; c <= 14; c++) begin
      ciclo();
      @(negedge clk);
      v = obs();
      e = esperado(c, 12, 28, 28, 28, 36);
      checks++;
      if (v !== e) begin
        failures++;
        $display("FAIL reset_medio_rearme c=%0d got=%h exp=%h", c, v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_negro();
    test_moca();
    test_cancelar();
    test_cancelar_servir();
    test_nivel();
    test_cambio_tipo();
    test_cancelar_reposo();
    test_reset_medio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
